// File: rtl/ibex_regfile_resync.sv
// Register-file resynchronisation sequencer: copies or compares registers 1..N-1
// between a healthy source file and a destination file after a lockstep setback.
module ibex_regfile_resync #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 mismatch_o,
  output logic [4:0]           mismatch_addr_o,
  output logic [4:0]           src_raddr_o,
  input  logic [DataWidth-1:0] src_rdata_i,
  output logic [4:0]           dst_raddr_o,
  input  logic [DataWidth-1:0] dst_rdata_i,
  output logic [4:0]           dst_waddr_o,
  output logic [DataWidth-1:0] dst_wdata_o,
  output logic                 dst_we_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam logic [4:0]  LastAddr  = 5'((1 << AddrWidth) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           cnt_q;
  logic [4:0]           addr_q;
  logic [4:0]           mm_addr_q;
  logic [DataWidth-1:0] src_q, dst_q;
  logic                 v_q, mode_q, mm_q;
  logic                 active, accept, stage2;

  assign active = (state_q == RUN) || (state_q == DRAIN);
  assign accept = (state_q == IDLE) && start_i && !abort_i;
  // Stage 2 is suppressed in an abort cycle so nothing commits while terminating.
  assign stage2 = v_q && active && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (abort_i)                state_d = IDLE;
        else if (cnt_q == LastAddr) state_d = DRAIN;
      end
      DRAIN:   state_d = abort_i ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      v_q       <= 1'b0;
      mode_q    <= 1'b0;
      mm_q      <= 1'b0;
      mm_addr_q <= '0;
    end else begin
      if (accept) begin
        mode_q    <= mode_i;
        mm_q      <= 1'b0;
        mm_addr_q <= '0;
        cnt_q     <= 5'd1;
      end

      if ((state_q == RUN) && !abort_i) begin
        addr_q <= cnt_q;
        src_q  <= src_rdata_i;
        dst_q  <= dst_rdata_i;
        v_q    <= 1'b1;
        cnt_q  <= cnt_q + 5'd1;
      end else begin
        v_q <= 1'b0;
      end

      if (stage2 && mode_q && (src_q != dst_q) && !mm_q) begin
        mm_q      <= 1'b1;
        mm_addr_q <= addr_q;
      end
    end
  end

  assign busy_o          = active;
  assign done_o          = (state_q == DONE);
  assign mismatch_o      = mm_q;
  assign mismatch_addr_o = mm_addr_q;
  assign src_raddr_o     = (state_q == RUN) ? cnt_q : '0;
  assign dst_raddr_o     = (state_q == RUN) ? cnt_q : '0;
  assign dst_we_o        = stage2 && !mode_q;
  assign dst_waddr_o     = addr_q;
  assign dst_wdata_o     = src_q;

endmodule

// File: tb/tb_ibex_regfile_resync.sv
// Bench for ibex_regfile_resync: 32-entry and 16-entry instances driven from a
// vector table, with expected destination writes queued and popped as they occur.
module tb_ibex_regfile_resync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start0, start1, mode, abort;
  logic [1:0]      busy, done, mm, we;
  logic [1:0][4:0] mma, sra, dra, wa;
  logic [1:0][31:0] wd, srd, drd;

  logic [31:0] src_rf [2][32];
  logic [31:0] dst_rf [2][32];

  assign srd[0] = src_rf[0][sra[0]];
  assign drd[0] = dst_rf[0][dra[0]];
  assign srd[1] = src_rf[1][sra[1]];
  assign drd[1] = dst_rf[1][dra[1]];

  ibex_regfile_resync #(.RV32E(1'b0), .DataWidth(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .mode_i(mode), .abort_i(abort),
    .busy_o(busy[0]), .done_o(done[0]), .mismatch_o(mm[0]), .mismatch_addr_o(mma[0]),
    .src_raddr_o(sra[0]), .src_rdata_i(srd[0]), .dst_raddr_o(dra[0]), .dst_rdata_i(drd[0]),
    .dst_waddr_o(wa[0]), .dst_wdata_o(wd[0]), .dst_we_o(we[0])
  );

  ibex_regfile_resync #(.RV32E(1'b1), .DataWidth(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .mode_i(mode), .abort_i(abort),
    .busy_o(busy[1]), .done_o(done[1]), .mismatch_o(mm[1]), .mismatch_addr_o(mma[1]),
    .src_raddr_o(sra[1]), .src_rdata_i(srd[1]), .dst_raddr_o(dra[1]), .dst_rdata_i(drd[1]),
    .dst_waddr_o(wa[1]), .dst_wdata_o(wd[1]), .dst_we_o(we[1])
  );

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit         sel;       // 0: 32-entry instance, 1: 16-entry instance
    bit         mode;
    int         c1, c2;    // corrupted destination registers (0 = none)
    int         abort_at;  // cycle in which abort is held (0 = none)
    int         start_at;  // cycle with a spurious start (0 = none)
    bit         exp_mm;
    logic [4:0] exp_addr;
  } vec_t;

  wr_t  sbq[$];
  vec_t tbl[11];
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    bit aborted;
    wr_t e;
    n = v.sel ? 16 : 32;
    aborted = (v.abort_at != 0) && (v.abort_at <= n);
    for (int k = 0; k < 32; k++) begin
      src_rf[v.sel][k] = 32'hA500_0000 | 32'(k);
      dst_rf[v.sel][k] = v.mode ? src_rf[v.sel][k] : 32'h0;
    end
    if (v.c1 != 0) dst_rf[v.sel][v.c1] = ~src_rf[v.sel][v.c1];
    if (v.c2 != 0) dst_rf[v.sel][v.c2] = ~src_rf[v.sel][v.c2];
    if (!v.mode)
      for (int k = 1; k < n; k++)
        if (!aborted || (k + 1 < v.abort_at))
          sbq.push_back('{k + 1, 5'(k), src_rf[v.sel][k]});

    @(negedge clk);
    mode = v.mode;
    if (v.sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;

    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      abort = (c == v.abort_at);
      if (v.sel) start1 = (c == v.start_at); else start0 = (c == v.start_at);
      #1;
      if (we[v.sel]) begin
        if (sbq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected write c%0d: got addr %0d data %0h, expected no write",
                   c, wa[v.sel], wd[v.sel]);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("write cycle c%0d", c), 32'(c), 32'(e.cyc));
          chk($sformatf("write addr c%0d", c), 32'(wa[v.sel]), 32'(e.addr));
          chk($sformatf("write data c%0d", c), wd[v.sel], e.data);
        end
      end
      chk($sformatf("busy c%0d", c), 32'(busy[v.sel]),
          32'((c <= n) && !(aborted && c > v.abort_at)));
      chk($sformatf("done c%0d", c), 32'(done[v.sel]), 32'((c == n + 1) && !aborted));
      if (c == 1) begin
        chk("mismatch cleared at start", 32'(mm[v.sel]), 32'h0);
        chk("mismatch addr cleared at start", 32'(mma[v.sel]), 32'h0);
      end
    end
    abort  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    chk("writes outstanding", 32'(sbq.size()), 32'h0);
    sbq.delete();
    chk("mismatch", 32'(mm[v.sel]), 32'(v.exp_mm));
    chk("mismatch addr", 32'(mma[v.sel]), 32'(v.exp_addr));
    repeat (3) @(negedge clk);
    chk("mismatch held", 32'(mm[v.sel]), 32'(v.exp_mm));
    chk("mismatch addr held", 32'(mma[v.sel]), 32'(v.exp_addr));
  endtask

  initial begin
    //         sel  mode c1  c2  abort start mm  addr
    tbl[0]  = '{1'b0, 1'b0, 0,  0,  0,  0, 1'b0, 5'd0};
    tbl[1]  = '{1'b0, 1'b1, 0,  0,  0,  0, 1'b0, 5'd0};
    tbl[2]  = '{1'b0, 1'b1, 7,  20, 0,  0, 1'b1, 5'd7};
    tbl[3]  = '{1'b0, 1'b0, 0,  0,  10, 0, 1'b0, 5'd0};
    tbl[4]  = '{1'b0, 1'b0, 0,  0,  0,  0, 1'b0, 5'd0};
    tbl[5]  = '{1'b1, 1'b0, 0,  0,  0,  5, 1'b0, 5'd0};
    tbl[6]  = '{1'b1, 1'b1, 3,  12, 0,  0, 1'b1, 5'd3};
    tbl[7]  = '{1'b0, 1'b1, 31, 0,  0,  0, 1'b1, 5'd31};
    tbl[8]  = '{1'b0, 1'b0, 0,  0,  32, 0, 1'b0, 5'd0};
    tbl[9]  = '{1'b1, 1'b0, 0,  0,  17, 0, 1'b0, 5'd0};
    tbl[10] = '{1'b0, 1'b1, 20, 0,  15, 0, 1'b0, 5'd0};

    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 32; k++) begin
        src_rf[s][k] = '0;
        dst_rf[s][k] = '0;
      end

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 1'b0; abort = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset busy%0d", s), 32'(busy[s]), 32'h0);
      chk($sformatf("reset done%0d", s), 32'(done[s]), 32'h0);
      chk($sformatf("reset mismatch%0d", s), 32'(mm[s]), 32'h0);
      chk($sformatf("reset we%0d", s), 32'(we[s]), 32'h0);
      chk($sformatf("reset raddr%0d", s), 32'({sra[s], dra[s], mma[s]}), 32'h0);
      chk($sformatf("reset waddr%0d", s), 32'(wa[s]), 32'h0);
      chk($sformatf("reset wdata%0d", s), wd[s], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run(tbl[i]);

    // Start together with abort in IDLE must not launch a sequence.
    @(negedge clk);
    start0 = 1'b1;
    abort  = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    abort  = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("start+abort busy c%0d", c), 32'(busy[0]), 32'h0);
      chk($sformatf("start+abort we c%0d", c), 32'(we[0]), 32'h0);
      chk($sformatf("start+abort done c%0d", c), 32'(done[0]), 32'h0);
    end

    // Asynchronous reset in the middle of a copy.
    mode   = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("pre-reset we", 32'(we[0]), 32'h1);
    chk("pre-reset busy", 32'(busy[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset we", 32'(we[0]), 32'h0);
    chk("async reset busy", 32'(busy[0]), 32'h0);
    chk("async reset waddr", 32'(wa[0]), 32'h0);
    chk("async reset raddr", 32'(sra[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
